alu_core: RTL and testbench

//   RV32I integer ALU for the single-threaded RISC-V core's execute stage.

---
 rtl/alu_core_if.sv | 45 ++++
 rtl/alu_core.sv | 121 ++++++++++++
 tb/tb_alu_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_core_if
// Purpose  : Operand/opcode and result/flag bundle for the RV32I execute ALU.
//            The optional OVF signal exists only when ALU_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_core_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [2:0]      func;
    logic            sub_sra;
    logic [4:0]      shamt;

    logic            out_valid;
    logic [XLEN-1:0] Q;
    logic            EQ;
    logic            A_less_than_B_signed;
    logic            A_less_than_B_unsigned;
`ifdef ALU_OVF_EN
    logic            OVF;
`endif

    // Issue side: drives operands, observes registered results
    modport master (
        output in_valid, A, B, func, sub_sra, shamt,
        input  out_valid, Q, EQ, A_less_than_B_signed, A_less_than_B_unsigned
`ifdef ALU_OVF_EN
        , input OVF
`endif
    );

    // ALU side: consumes operands, produces registered results
    modport slave (
        input  in_valid, A, B, func, sub_sra, shamt,
        output out_valid, Q, EQ, A_less_than_B_signed, A_less_than_B_unsigned
`ifdef ALU_OVF_EN
        , output OVF
`endif
    );
endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : RV32I integer ALU with registered result and compare flags
//            (1-cycle latency, one operation accepted per cycle).
//            Optional feature macro: ALU_OVF_EN (adds signed ADD/SUB overflow).
// Revision : 1.0 - initial release
// ============================================================================
module alu_core #(
    parameter int XLEN = 32
) (
    input wire        clk,
    input wire        rst_n,
    alu_core_if.slave bus
);
    localparam logic [2:0] c_FUNC_ADD  = 3'd0;
    localparam logic [2:0] c_FUNC_SLL  = 3'd1;
    localparam logic [2:0] c_FUNC_SLT  = 3'd2;
    localparam logic [2:0] c_FUNC_SLTU = 3'd3;
    localparam logic [2:0] c_FUNC_XOR  = 3'd4;
    localparam logic [2:0] c_FUNC_SRL  = 3'd5;
    localparam logic [2:0] c_FUNC_OR   = 3'd6;
    localparam logic [2:0] c_FUNC_AND  = 3'd7;

    logic [XLEN-1:0] w_b_op;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_sra;
    logic [XLEN-1:0] w_result;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;

    logic            r_valid;
    logic [XLEN-1:0] r_q;
    logic            r_eq;
    logic            r_lt_s;
    logic            r_lt_u;

    // Adder shared by ADD and SUB: subtraction is A + ~B + 1
    always_comb begin
        w_b_op = bus.sub_sra ? ~bus.B : bus.B;
        w_sum  = bus.A + w_b_op + {{(XLEN-1){1'b0}}, bus.sub_sra};
    end

    // Arithmetic shift kept on its own so the signed operand is not
    // turned unsigned by a surrounding mixed-sign expression
    always_comb begin
        w_sra = $signed(bus.A) >>> bus.shamt;
    end

    // Compare flags, evaluated every cycle regardless of func
    always_comb begin
        w_eq   = (bus.A == bus.B);
        w_lt_s = ($signed(bus.A) < $signed(bus.B));
        w_lt_u = (bus.A < bus.B);
    end

    // funct3 result select
    always_comb begin
        w_result = '0;
        case (bus.func)
            c_FUNC_ADD:  w_result = w_sum;
            c_FUNC_SLL:  w_result = bus.A << bus.shamt;
            c_FUNC_SLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_s};
            c_FUNC_SLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_u};
            c_FUNC_XOR:  w_result = bus.A ^ bus.B;
            c_FUNC_SRL:  w_result = bus.sub_sra ? w_sra : (bus.A >> bus.shamt);
            c_FUNC_OR:   w_result = bus.A | bus.B;
            c_FUNC_AND:  w_result = bus.A & bus.B;
            default:     w_result = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: effective operands share a sign that the sum lost
    always_comb begin
        w_ovf = (bus.func == c_FUNC_ADD) &&
                (bus.A[XLEN-1] == w_b_op[XLEN-1]) &&
                (w_sum[XLEN-1] != bus.A[XLEN-1]);
    end
`endif

    // Output registers: load on valid, hold otherwise; valid tracks in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_q     <= '0;
            r_eq    <= 1'b0;
            r_lt_s  <= 1'b0;
            r_lt_u  <= 1'b0;
`ifdef ALU_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_q    <= w_result;
                r_eq   <= w_eq;
                r_lt_s <= w_lt_s;
                r_lt_u <= w_lt_u;
`ifdef ALU_OVF_EN
                r_ovf  <= w_ovf;
`endif
            end
        end
    end

    assign bus.out_valid              = r_valid;
    assign bus.Q                      = r_q;
    assign bus.EQ                     = r_eq;
    assign bus.A_less_than_B_signed   = r_lt_s;
    assign bus.A_less_than_B_unsigned = r_lt_u;
`ifdef ALU_OVF_EN
    assign bus.OVF                    = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_core
// Purpose  : Self-checking bench for alu_core. Expected results are queued
//            when an operation is issued and compared when out_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_core;
    typedef struct {
        logic [31:0] q;
        logic        eq;
        logic        lt_s;
        logic        lt_u;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];
    exp_t last;

    alu_core_if #(.XLEN(32)) bus ();

    alu_core #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from 33-bit signed arithmetic
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f, input logic s,
                                   input logic [4:0] sh);
        exp_t m;
        logic signed [32:0] wide;
        m.eq   = (a == b);
        m.lt_s = ($signed(a) < $signed(b));
        m.lt_u = (a < b);
        m.ovf  = 1'b0;
        m.q    = '0;
        case (f)
            3'd0: begin
                if (s) wide = $signed({a[31], a}) - $signed({b[31], b});
                else   wide = $signed({a[31], a}) + $signed({b[31], b});
                m.q   = wide[31:0];
                m.ovf = (wide[32] != wide[31]);
            end
            3'd1: m.q = a << sh;
            3'd2: m.q = {31'b0, m.lt_s};
            3'd3: m.q = {31'b0, m.lt_u};
            3'd4: m.q = a ^ b;
            3'd5: begin
                if (s) m.q = $signed(a) >>> sh;
                else   m.q = a >> sh;
            end
            3'd6: m.q = a | b;
            default: m.q = a & b;
        endcase
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".Q"},    bus.Q, e.q);
        check({tag, ".EQ"},   {31'b0, bus.EQ}, {31'b0, e.eq});
        check({tag, ".LTS"},  {31'b0, bus.A_less_than_B_signed}, {31'b0, e.lt_s});
        check({tag, ".LTU"},  {31'b0, bus.A_less_than_B_unsigned}, {31'b0, e.lt_u});
`ifdef ALU_OVF_EN
        check({tag, ".OVF"},  {31'b0, bus.OVF}, {31'b0, e.ovf});
`endif
    endtask

    // One clock cycle: apply inputs now, sample #1 after the next rising edge
    task automatic step(input string tag, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] f,
                        input logic s, input logic [4:0] sh);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.func     = f;
        bus.sub_sra  = s;
        bus.shamt    = sh;
        if (v) sb.push_back(model(a, b, f, s, sh));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, v});
        if (bus.out_valid === 1'b1) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
            end
            if (sb.size() > 0) begin
                last = sb.pop_front();
                check_outputs(tag, last);
            end
        end else begin
            check_outputs({tag, ".hold"}, last);
        end
    endtask

    task automatic check_reset_state(input string tag);
        exp_t z;
        z = '{q: '0, eq: 1'b0, lt_s: 1'b0, lt_u: 1'b0, ovf: 1'b0};
        check({tag, ".out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check_outputs(tag, z);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last  = '{q: '0, eq: 1'b0, lt_s: 1'b0, lt_u: 1'b0, ovf: 1'b0};
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.func     = '0;
        bus.sub_sra  = 1'b0;
        bus.shamt    = '0;

        #1;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;

        // Directed vectors
        step("add",      1'b1, 32'h12345000, 32'h67890000, 3'd0, 1'b0, 5'd0);
        step("sub",      1'b1, 32'h12345000, 32'h67890000, 3'd0, 1'b1, 5'd0);
        step("sra4",     1'b1, 32'h80000000, 32'h00000000, 3'd5, 1'b1, 5'd4);
        step("srl4",     1'b1, 32'h80000000, 32'h00000000, 3'd5, 1'b0, 5'd4);
        step("slt",      1'b1, 32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b0, 5'd0);
        step("sltu",     1'b1, 32'hFFFFFFFF, 32'h00000001, 3'd3, 1'b1, 5'd0);
        step("xor_eq",   1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, 3'd4, 1'b0, 5'd0);
        step("sll0",     1'b1, 32'hDEADBEEF, 32'h00000003, 3'd1, 1'b1, 5'd0);
        step("sll31",    1'b1, 32'hDEADBEEF, 32'h00000003, 3'd1, 1'b0, 5'd31);
        step("sra31",    1'b1, 32'h80000001, 32'h00000000, 3'd5, 1'b1, 5'd31);
        step("srl31",    1'b1, 32'h80000001, 32'h00000000, 3'd5, 1'b0, 5'd31);
        step("sra0",     1'b1, 32'hC0FFEE00, 32'h00000000, 3'd5, 1'b1, 5'd0);
        step("or",       1'b1, 32'hF0F00000, 32'h0000F0F0, 3'd6, 1'b1, 5'd7);
        step("and",      1'b1, 32'hFF00FF00, 32'h0FF00FF0, 3'd7, 1'b0, 5'd0);
        step("add_wrap", 1'b1, 32'hFFFFFFFF, 32'h00000002, 3'd0, 1'b0, 5'd0);
        step("ovf_add",  1'b1, 32'h7FFFFFFF, 32'h00000001, 3'd0, 1'b0, 5'd0);
        step("ovf_sub",  1'b1, 32'h80000000, 32'h00000001, 3'd0, 1'b1, 5'd0);
        step("noovf_or", 1'b1, 32'h7FFFFFFF, 32'h00000001, 3'd6, 1'b0, 5'd0);

        // Idle cycles: outputs must hold the last result
        step("idle1", 1'b0, 32'h11111111, 32'h22222222, 3'd0, 1'b0, 5'd0);
        step("idle2", 1'b0, 32'h33333333, 32'h33333333, 3'd4, 1'b0, 5'd0);

        // Back-to-back random operations
        for (int i = 0; i < 24; i++) begin
            step("rand", 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset between edges discards the pending operation
        step("pre_rst", 1'b1, 32'h00000005, 32'h00000003, 3'd0, 1'b0, 5'd0);
        bus.in_valid = 1'b1;
        bus.A        = 32'h00000100;
        bus.B        = 32'h00000200;
        bus.func     = 3'd6;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        sb.delete();
        last = '{q: '0, eq: 1'b0, lt_s: 1'b0, lt_u: 1'b0, ovf: 1'b0};
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 32'h00000100, 32'h00000200, 3'd6, 1'b0, 5'd0);
        step("post_rst_op",   1'b1, 32'h00000100, 32'h00000200, 3'd6, 1'b0, 5'd0);
        step("post_rst_hold", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
